// File: rtl/nios_noc_send_ctrl_if.sv
// NoC-side bundle for nios_noc_send_ctrl: send port with valid/ready,
// receive port with single-cycle valid and no backpressure.
interface nios_noc_send_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] noc_send_addr;
  logic [DATA_W-1:0] noc_send_data;
  logic              noc_send_valid;
  logic              noc_send_ready;
  logic [DATA_W-1:0] noc_recv_data;
  logic              noc_recv_valid;

  modport master (
    output noc_send_addr,
    output noc_send_data,
    output noc_send_valid,
    input  noc_send_ready,
    input  noc_recv_data,
    input  noc_recv_valid
  );

  modport slave (
    input  noc_send_addr,
    input  noc_send_data,
    input  noc_send_valid,
    output noc_send_ready,
    output noc_recv_data,
    output noc_recv_valid
  );
endinterface

// File: rtl/nios_noc_send_ctrl.sv
// Nios PIO to NoC send sequencer with RX FIFO read back through a PIO.
// Optional TX_TIMEOUT_EN: bounded wait for noc_send_ready, sets tx_err.
module nios_noc_send_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RX_DEPTH = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pio_addr,
  input  logic [DATA_W-1:0] pio_data,
  input  logic              pio_ack,
  input  logic              pio_pop,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] pio_rdata,
  output logic [7:0]        pio_status,
  nios_noc_send_ctrl_if.master noc
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  if (RX_DEPTH < 2 || RX_DEPTH > 8 ||
      (RX_DEPTH & (RX_DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("nios_noc_send_ctrl: bad RX_DEPTH/TIMEOUT");
  end

  logic              ack_q, pop_q;
  logic              ack_ev, pop_ev;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic              tx_ovf_q, tx_ovf_set;
  logic              rx_ovf_q, rx_ovf_set;
  logic              tx_err;

  assign ack_ev = pio_ack ^ ack_q;
  assign pop_ev = pio_pop ^ pop_q;

`ifdef TX_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] timer_q;
  logic       tx_err_q, tx_err_set;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    pend_d     = pend_q;
    paddr_d    = paddr_q;
    pdata_d    = pdata_q;
    tx_ovf_set = 1'b0;
`ifdef TX_TIMEOUT_EN
    tx_err_set = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = SEND;
          addr_d  = paddr_q;
          data_d  = pdata_q;
          pend_d  = ack_ev;
          if (ack_ev) begin
            paddr_d = pio_addr;
            pdata_d = pio_data;
          end
        end else if (ack_ev) begin
          state_d = SEND;
          addr_d  = pio_addr;
          data_d  = pio_data;
        end
      end
      SEND: begin
        // one-deep queue; a request arriving while it is full is lost
        if (ack_ev) begin
          if (pend_q) begin
            tx_ovf_set = 1'b1;
          end else begin
            pend_d  = 1'b1;
            paddr_d = pio_addr;
            pdata_d = pio_data;
          end
        end
        if (noc.noc_send_ready) begin
          state_d = IDLE;
`ifdef TX_TIMEOUT_EN
        end else if (timer_q == TO_LAST) begin
          state_d    = IDLE;
          tx_err_set = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= 1'b0;
      pop_q    <= 1'b0;
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      pend_q   <= 1'b0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      ack_q    <= pio_ack;
      pop_q    <= pio_pop;
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      paddr_q  <= paddr_d;
      pdata_q  <= pdata_d;
      tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~clr_flags);
      rx_ovf_q <= rx_ovf_set | (rx_ovf_q & ~clr_flags);
    end
  end

`ifdef TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= '0;
      tx_err_q <= 1'b0;
    end else begin
      timer_q  <= (state_q == SEND) ? timer_q + 8'd1 : 8'd0;
      tx_err_q <= tx_err_set | (tx_err_q & ~clr_flags);
    end
  end
  assign tx_err = tx_err_q;
`else
  assign tx_err = 1'b0;
`endif

  assign noc.noc_send_valid = (state_q == SEND);
  assign noc.noc_send_addr  = addr_q;
  assign noc.noc_send_data  = data_q;

  logic [DATA_W-1:0] mem_q [RX_DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [3:0]        cnt_q;
  logic              empty, full, push, pop;

  assign empty = (cnt_q == 4'd0);
  assign full  = (cnt_q == 4'(RX_DEPTH));
  assign pop   = pop_ev & ~empty;
  // at full, a same-cycle pop frees the slot the new word lands in
  assign push       = noc.noc_recv_valid & (~full | pop);
  assign rx_ovf_set = noc.noc_recv_valid & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + 4'(push) - 4'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= noc.noc_recv_data;
  end

  assign pio_rdata  = empty ? '0 : mem_q[rp_q];
  assign pio_status = {cnt_q, tx_ovf_q, rx_ovf_q, tx_err,
                       (state_q == SEND) | pend_q};

endmodule

// File: tb/tb_nios_noc_send_ctrl.sv
// Scoreboard bench for nios_noc_send_ctrl: TX words and RX FIFO heads
// are predicted into queues and checked as the DUT produces them.
module tb_nios_noc_send_ctrl;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int RX_DEPTH = 4;
  localparam int TIMEOUT  = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] pio_addr = '0;
  logic [DATA_W-1:0] pio_data = '0;
  logic              pio_ack = 1'b0;
  logic              pio_pop = 1'b0;
  logic              clr_flags = 1'b0;
  logic [DATA_W-1:0] pio_rdata;
  logic [7:0]        pio_status;

  nios_noc_send_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) noc ();

  nios_noc_send_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RX_DEPTH(RX_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pio_addr(pio_addr), .pio_data(pio_data),
    .pio_ack(pio_ack), .pio_pop(pio_pop),
    .clr_flags(clr_flags),
    .pio_rdata(pio_rdata), .pio_status(pio_status),
    .noc(noc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  logic [ADDR_W+DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0]        rx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && noc.noc_send_valid && noc.noc_send_ready) begin
      chk("tx_expected", 64'(tx_q.size() != 0), 64'd1);
      if (tx_q.size() != 0)
        chk("tx_word", 64'({noc.noc_send_addr, noc.noc_send_data}),
            64'(tx_q.pop_front()));
      tx_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input bit expect_tx);
    pio_addr = a;
    pio_data = d;
    pio_ack  = ~pio_ack;
    if (expect_tx) tx_q.push_back({a, d});
    tick();
  endtask

  task automatic recv(input logic [DATA_W-1:0] d, input bit do_pop);
    noc.noc_recv_data  = d;
    noc.noc_recv_valid = 1'b1;
    if (do_pop) begin
      pio_pop = ~pio_pop;
      if (rx_q.size() != 0) chk("rx_head_pp", 64'(pio_rdata), 64'(rx_q.pop_front()));
    end
    if (rx_q.size() < RX_DEPTH) rx_q.push_back(d);
    tick();
    noc.noc_recv_valid = 1'b0;
  endtask

  task automatic pop_rx();
    if (rx_q.size() != 0) chk("rx_head", 64'(pio_rdata), 64'(rx_q.pop_front()));
    pio_pop = ~pio_pop;
    tick();
  endtask

  task automatic wait_tx_drain(input int limit);
    for (int i = 0; i < limit && tx_q.size() != 0; i++) tick();
    chk("tx_drain", 64'(tx_q.size()), 64'd0);
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    noc.noc_send_ready = 1'b0;
    noc.noc_recv_data  = '0;
    noc.noc_recv_valid = 1'b0;
    #3;
    chk("rst_valid", 64'(noc.noc_send_valid), 64'd0);
    chk("rst_status", 64'(pio_status), 64'd0);
    chk("rst_rdata", 64'(pio_rdata), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // single send, ready high
    noc.noc_send_ready = 1'b1;
    ack(8'h05, 32'hDEADBEEF, 1'b1);
    chk("t1_busy", 64'(pio_status[0]), 64'd1);
    chk("t1_valid", 64'(noc.noc_send_valid), 64'd1);
    tick();
    chk("t1_idle", 64'(pio_status[0]), 64'd0);
    chk("t1_vlow", 64'(noc.noc_send_valid), 64'd0);
    chk("t1_seen", 64'(tx_seen), 64'd1);

    // pend and overflow under backpressure
    noc.noc_send_ready = 1'b0;
    ack(8'hA1, 32'h1111_0001, 1'b1);
    ack(8'hB2, 32'h2222_0002, 1'b1);
    ack(8'hC3, 32'h3333_0003, 1'b0);
    chk("t2_ovf", 64'(pio_status[3]), 64'd1);
    chk("t2_busy", 64'(pio_status[0]), 64'd1);
    noc.noc_send_ready = 1'b1;
    wait_tx_drain(10);
    tick();
    chk("t2_idle", 64'(pio_status[0]), 64'd0);
    chk("t2_seen", 64'(tx_seen), 64'd3);
    chk("t2_sticky", 64'(pio_status[3]), 64'd1);
    clear_flags();
    chk("t2_clr", 64'(pio_status[3]), 64'd0);

    // RX overflow and drain
    for (int i = 1; i <= 5; i++) recv(32'(i), 1'b0);
    chk("rx_cnt4", 64'(pio_status[7:4]), 64'd4);
    chk("rx_ovf", 64'(pio_status[2]), 64'd1);
    chk("rx_rd1", 64'(pio_rdata), 64'd1);
    for (int i = 0; i < 4; i++) pop_rx();
    chk("rx_empty_rd", 64'(pio_rdata), 64'd0);
    chk("rx_cnt0", 64'(pio_status[7:4]), 64'd0);
    clear_flags();
    pop_rx();
    chk("rx_pop_empty_cnt", 64'(pio_status[7:4]), 64'd0);
    chk("rx_pop_empty_ovf", 64'(pio_status[2]), 64'd0);

    // push and pop together at full
    for (int i = 0; i < 4; i++) recv(32'h10 + 32'(i), 1'b0);
    recv(32'h99, 1'b1);
    chk("rx_full_cnt", 64'(pio_status[7:4]), 64'd4);
    chk("rx_full_ovf", 64'(pio_status[2]), 64'd0);
    for (int i = 0; i < 4; i++) pop_rx();
    chk("rx_cnt_end", 64'(pio_status[7:4]), 64'd0);
    recv(32'h77, 1'b1);
    chk("rx_pp_empty", 64'(pio_status[7:4]), 64'd1);
    pop_rx();

`ifdef TX_TIMEOUT_EN
    noc.noc_send_ready = 1'b0;
    ack(8'h44, 32'h4444_4444, 1'b0);
    cnt = 0;
    for (int i = 0; i < 30 && noc.noc_send_valid; i++) begin
      cnt++;
      tick();
    end
    chk("to_cycles", 64'(cnt), 64'(TIMEOUT));
    chk("to_err", 64'(pio_status[1]), 64'd1);
    chk("to_busy", 64'(pio_status[0]), 64'd0);
    clear_flags();
    chk("to_clr", 64'(pio_status[1]), 64'd0);
`else
    noc.noc_send_ready = 1'b0;
    ack(8'h44, 32'h4444_4444, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40 && noc.noc_send_valid; i++) begin
      cnt++;
      tick();
    end
    chk("nto_wait", 64'(cnt), 64'd40);
    chk("nto_err", 64'(pio_status[1]), 64'd0);
    noc.noc_send_ready = 1'b1;
    wait_tx_drain(5);
`endif

    // asynchronous reset in the middle of a send
    noc.noc_send_ready = 1'b0;
    ack(8'h3C, 32'h1234_5678, 1'b1);
    recv(32'hAB, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(noc.noc_send_valid), 64'd0);
    chk("ar_status", 64'(pio_status), 64'd0);
    chk("ar_rdata", 64'(pio_rdata), 64'd0);
    chk("ar_data", 64'(noc.noc_send_data), 64'd0);
    tx_q.delete();
    rx_q.delete();
    pio_ack = 1'b0;
    pio_pop = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_rel_status", 64'(pio_status), 64'd0);
    chk("ar_rel_valid", 64'(noc.noc_send_valid), 64'd0);

    noc.noc_send_ready = 1'b1;
    ack(8'h7F, 32'hCAFE_F00D, 1'b1);
    wait_tx_drain(5);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
